keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. Rows are
// synchronised, and each press and each release is debounced before it is
// accepted. When a press is accepted, the scanner reports its hex code
// together with a one-cycle strobe.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   row[3:0]   keypad rows, active low, asynchronous to clock
//   col[3:0]   column drive, active low, exactly one bit low
//   key_val    hex code of the last accepted key
//   key_valid  one-cycle pulse, one cycle after key_val/key_held update
//   key_held   high while the accepted key stays pressed
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_val,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Index of the lowest low row; callers only use it when some bit is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rs);
        logic [1:0] idx;
        if (rs[0] == 1'b0) begin
            idx = 2'd0;
        end else if (rs[1] == 1'b0) begin
            idx = 2'd1;
        end else if (rs[2] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Keypad legend: column 0 is leftmost, row 0 is the top row.
    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      row_meta_r;
    logic [3:0]      rs_r;
    logic [TW-1:0]   tick_r;
    logic [TW-1:0]   tick_nxt_s;
    logic [1:0]      col_idx_r;
    logic [1:0]      col_idx_nxt_s;
    logic [1:0]      row_idx_r;
    logic [1:0]      row_idx_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [3:0]      col_r;
    logic [3:0]      col_nxt_s;
    logic [3:0]      key_val_r;
    logic [3:0]      key_val_nxt_s;
    logic            key_held_r;
    logic            key_held_nxt_s;
    logic            key_valid_r;
    logic            valid_pend_r;
    logic            pend_nxt_s;

    logic            sample_s;
    logic            any_low_s;
    logic [1:0]      low_row_s;
    logic            last_match_s;
    logic            accept_s;
    logic            release_s;
    logic            advance_s;
    logic            latch_s;

    assign sample_s     = (tick_r == TW'(SCAN_TICKS - 1));
    assign any_low_s    = (rs_r != 4'hF);
    assign low_row_s    = lowest_low(rs_r);
    // True when one more matching sample completes the debounce run.
    assign last_match_s = ((int'(cnt_r) + 1) >= DEBOUNCE_SCANS);

    // Two-flop synchroniser on the asynchronous row inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta_r <= 4'hF;
            rs_r       <= 4'hF;
        end else begin
            row_meta_r <= row;
            rs_r       <= row_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_SCAN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and debounce decisions, evaluated only at sample instants.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        release_s   = 1'b0;
        advance_s   = 1'b0;
        latch_s     = 1'b0;
        if (sample_s) begin
            case (state_r)
                ST_SCAN: begin
                    if (!any_low_s) begin
                        advance_s = 1'b1;
                    end else begin
                        latch_s = 1'b1;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept_s    = 1'b1;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_HELD;
                        end else begin
                            cnt_nxt_s   = CW'(1);
                            state_nxt_s = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (any_low_s && (low_row_s == row_idx_r)) begin
                        if (last_match_s) begin
                            accept_s    = 1'b1;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_HELD;
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        // Bounce or a different row: drop it silently.
                        advance_s   = 1'b1;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Only the latched row matters; other rows are ignored.
                    if (rs_r[row_idx_r]) begin
                        if (last_match_s) begin
                            release_s   = 1'b1;
                            advance_s   = 1'b1;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_SCAN;
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_nxt_s = '0;
                    end
                end
                default: begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_SCAN;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        tick_nxt_s     = sample_s ? '0 : (tick_r + TW'(1));
        col_idx_nxt_s  = advance_s ? (col_idx_r + 2'd1) : col_idx_r;
        col_nxt_s      = ~(4'b0001 << col_idx_nxt_s);
        row_idx_nxt_s  = latch_s ? low_row_s : row_idx_r;
        pend_nxt_s     = accept_s;
        // In CONFIRM an accept implies low_row_s equals the latched row.
        key_val_nxt_s  = accept_s ? key_map(col_idx_r, low_row_s) : key_val_r;
        if (accept_s) begin
            key_held_nxt_s = 1'b1;
        end else if (release_s) begin
            key_held_nxt_s = 1'b0;
        end else begin
            key_held_nxt_s = key_held_r;
        end
    end

    // Datapath and output registers; the strobe trails the accept by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_r       <= '0;
            col_idx_r    <= 2'd0;
            row_idx_r    <= 2'd0;
            cnt_r        <= '0;
            col_r        <= 4'b1110;
            key_val_r    <= 4'h0;
            key_held_r   <= 1'b0;
            valid_pend_r <= 1'b0;
            key_valid_r  <= 1'b0;
        end else begin
            tick_r       <= tick_nxt_s;
            col_idx_r    <= col_idx_nxt_s;
            row_idx_r    <= row_idx_nxt_s;
            cnt_r        <= cnt_nxt_s;
            col_r        <= col_nxt_s;
            key_val_r    <= key_val_nxt_s;
            key_held_r   <= key_held_nxt_s;
            valid_pend_r <= pend_nxt_s;
            key_valid_r  <= valid_pend_r;
        end
    end

    assign col       = col_r;
    assign key_val   = key_val_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=3.
// The keypad is modelled as row[r]=0 iff key (c,r) is pressed and col[c]==0.
module tb_keypad_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_val;
    logic        key_valid;
    logic        key_held;

    logic [3:0][3:0] press;   // press[r][c]
    int          passed;
    int          total;
    int          pulse_cnt;
    int          base;

    keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_val  (key_val),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix model.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(press[r] & ~col);
        end
    end

    // Count strobe cycles.
    always @(posedge clock) begin
        if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_held(input logic v, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (key_held === v) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {7'd0, seen}, 8'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (key_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {7'd0, seen}, 8'd1);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        pulse_cnt = 0;
        press     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_col",   {4'd0, col}, 8'h0E);
        check("rst_val",   {4'd0, key_val}, 8'h00);
        check("rst_valid", {7'd0, key_valid}, 8'h00);
        check("rst_held",  {7'd0, key_held}, 8'h00);

        // 1: idle scan, each column for 4 cycles.
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check("idle_col",   {4'd0, col}, {4'd0, exp_col});
            check("idle_valid", {7'd0, key_valid}, 8'h00);
            @(negedge clock);
        end
        check("idle_val", {4'd0, key_val}, 8'h00);

        // 2: hold key 5; held rises first, strobe one cycle later.
        base = pulse_cnt;
        press[1][1] = 1'b1;
        wait_held(1'b1, "k5_held_rise");
        check("k5_val",          {4'd0, key_val}, 8'h05);
        check("k5_valid_not_yet", {7'd0, key_valid}, 8'h00);
        @(negedge clock);
        check("k5_valid_pulse",  {7'd0, key_valid}, 8'h01);
        @(negedge clock);
        check("k5_valid_drop",   {7'd0, key_valid}, 8'h00);
        repeat (200) @(negedge clock);
        check("k5_pulses", 8'(pulse_cnt - base), 8'd1);
        check("k5_col_frozen", {4'd0, col}, 8'h0D);
        check("k5_still_held", {7'd0, key_held}, 8'h01);
        press = '0;
        wait_held(1'b0, "k5_release");
        check("k5_col_after", {4'd0, col}, 8'h0B);
        check("k5_pulses_rel", 8'(pulse_cnt - base), 8'd1);

        // 3: key 9 low for only the first sample of column 2.
        press[2][2] = 1'b1;
        repeat (4) @(negedge clock);
        press = '0;
        repeat (3) @(negedge clock);
        check("bounce_col_hold", {4'd0, col}, 8'h0B);
        @(negedge clock);
        check("bounce_col_adv", {4'd0, col}, 8'h07);
        check("bounce_pulses", 8'(pulse_cnt - base), 8'd1);
        check("bounce_val", {4'd0, key_val}, 8'h05);

        // 4: D, then 0, then A.
        press[3][3] = 1'b1;
        wait_valid("kD_pulse");
        check("kD_val", {4'd0, key_val}, 8'h0D);
        press = '0;
        wait_held(1'b0, "kD_release");
        press[3][0] = 1'b1;
        wait_valid("k0_pulse");
        check("k0_val", {4'd0, key_val}, 8'h00);
        check("k0_held", {7'd0, key_held}, 8'h01);
        press = '0;
        wait_held(1'b0, "k0_release");
        press[0][3] = 1'b1;
        wait_valid("kA_pulse");
        check("kA_val", {4'd0, key_val}, 8'h0A);
        press = '0;
        wait_held(1'b0, "kA_release");

        // 5: keys 1 and 7 together; the top row wins.
        base = pulse_cnt;
        press[0][0] = 1'b1;
        press[2][0] = 1'b1;
        wait_valid("k17_pulse");
        check("k17_val", {4'd0, key_val}, 8'h01);
        repeat (100) @(negedge clock);
        check("k17_pulses", 8'(pulse_cnt - base), 8'd1);
        press = '0;
        wait_held(1'b0, "k17_release");

        // 6: reset in the cycle after accept cancels the pending strobe.
        press[2][1] = 1'b1;
        wait_held(1'b1, "k8_held");
        reset = 1'b1;
        base  = pulse_cnt;
        @(negedge clock);
        reset = 1'b0;
        check("rst8_col",   {4'd0, col}, 8'h0E);
        check("rst8_held",  {7'd0, key_held}, 8'h00);
        check("rst8_val",   {4'd0, key_val}, 8'h00);
        check("rst8_valid", {7'd0, key_valid}, 8'h00);
        check("rst8_no_pulse", 8'(pulse_cnt - base), 8'd0);
        wait_valid("k8_pulse");
        check("k8_val", {4'd0, key_val}, 8'h08);
        repeat (50) @(negedge clock);
        check("k8_pulses", 8'(pulse_cnt - base), 8'd1);
        press = '0;
        wait_held(1'b0, "k8_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
